// File: rtl/data_selector_4cell.sv
// -----------------------------------------------------------------------------
// data_selector_4cell
//
// Purpose:
//   Four-entry scratch store with a single registered output and a
//   direct-data bypass. Each clock edge carries one command, selected by the
//   pair {read_sig_i, write_sig_i}:
//     00 idle   : cells and data_o hold
//     10 store  : cell[adr_i] <= data_i, data_o holds
//     01 fetch  : data_o <= cell[adr_i] (the value before this edge)
//     11 direct : data_o <= data_i, cells hold
//
// Optional feature (macro DS_DIRECT_WRITE_EN):
//   When defined, the direct command also writes data_i into cell[adr_i]
//   on the same edge (write-through). When undefined, direct leaves the
//   cells untouched.
//
// Ports:
//   clk_i        in   1       rising-edge clock
//   rst_ni       in   1       asynchronous active-low reset
//   data_i       in   DATA_W  store data or direct-data byte
//   adr_i        in   2       cell select (0..3 -> cell_1..cell_4)
//   read_sig_i   in   1       store strobe
//   write_sig_i  in   1       fetch strobe
//   data_o       out  DATA_W  registered output
// -----------------------------------------------------------------------------
module data_selector_4cell #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        adr_i,
    input  logic              read_sig_i,
    input  logic              write_sig_i,
    output logic [DATA_W-1:0] data_o
);

    // Cell storage; names are fixed because benches probe them directly.
    logic [DATA_W-1:0] cell_1;
    logic [DATA_W-1:0] cell_2;
    logic [DATA_W-1:0] cell_3;
    logic [DATA_W-1:0] cell_4;

    logic [DATA_W-1:0] r_data;

    logic              w_store;
    logic              w_fetch;
    logic              w_direct;
    logic              w_cell_we;
    logic [DATA_W-1:0] w_cell_rd;

    assign w_store  =  read_sig_i & ~write_sig_i;
    assign w_fetch  = ~read_sig_i &  write_sig_i;
    assign w_direct =  read_sig_i &  write_sig_i;

`ifdef DS_DIRECT_WRITE_EN
    // Direct mode writes through to the addressed cell as well.
    assign w_cell_we = w_store | w_direct;
`else
    assign w_cell_we = w_store;
`endif

    // Read mux sees the cells as they were before the edge, so a fetch on
    // the edge after a store returns the new value but there is no
    // same-edge forwarding.
    always_comb begin
        w_cell_rd = cell_1;
        case (adr_i)
            2'd0:    w_cell_rd = cell_1;
            2'd1:    w_cell_rd = cell_2;
            2'd2:    w_cell_rd = cell_3;
            default: w_cell_rd = cell_4;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cell_1 <= '0;
            cell_2 <= '0;
            cell_3 <= '0;
            cell_4 <= '0;
        end else if (w_cell_we) begin
            case (adr_i)
                2'd0:    cell_1 <= data_i;
                2'd1:    cell_2 <= data_i;
                2'd2:    cell_3 <= data_i;
                default: cell_4 <= data_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
        end else if (w_fetch) begin
            r_data <= w_cell_rd;
        end else if (w_direct) begin
            r_data <= data_i;
        end
    end

    assign data_o = r_data;

endmodule

// File: tb/tb_data_selector_4cell.sv
module tb_data_selector_4cell;

    logic       clk_i;
    logic       rst_ni;
    logic [7:0] data_i;
    logic [1:0] adr_i;
    logic       read_sig_i;
    logic       write_sig_i;
    logic [7:0] data_o;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [1:0] adr;
        logic [7:0] din;
        logic [7:0] q;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
        logic [7:0] c4;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

`ifdef DS_DIRECT_WRITE_EN
    localparam logic [7:0] C2D = 8'd123;  // cell_2 after direct a=1 d=123
    localparam logic [7:0] C4D = 8'd0;    // cell_4 after direct a=3 d=0
`else
    localparam logic [7:0] C2D = 8'd32;
    localparam logic [7:0] C4D = 8'd1;
`endif

    data_selector_4cell #(.DATA_W(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (data_i),
        .adr_i       (adr_i),
        .read_sig_i  (read_sig_i),
        .write_sig_i (write_sig_i),
        .data_o      (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q,
                           input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3, input logic [7:0] c4);
        chk({tag, ".data_o"}, data_o, q);
        chk({tag, ".cell_1"}, dut.cell_1, c1);
        chk({tag, ".cell_2"}, dut.cell_2, c2);
        chk({tag, ".cell_3"}, dut.cell_3, c3);
        chk({tag, ".cell_4"}, dut.cell_4, c4);
    endtask

    task automatic set_vec(input int i, input logic rd, input logic wr,
                           input logic [1:0] adr, input logic [7:0] din,
                           input logic [7:0] q, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3,
                           input logic [7:0] c4);
        vecs[i].rd  = rd;
        vecs[i].wr  = wr;
        vecs[i].adr = adr;
        vecs[i].din = din;
        vecs[i].q   = q;
        vecs[i].c1  = c1;
        vecs[i].c2  = c2;
        vecs[i].c3  = c3;
        vecs[i].c4  = c4;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //             rd    wr    adr   din      q        c1      c2      c3     c4
        set_vec( 0, 1'b1, 1'b0, 2'd0, 8'd64,   8'd0,    8'd64,  8'd0,   8'd0,  8'd0);
        set_vec( 1, 1'b1, 1'b0, 2'd1, 8'd32,   8'd0,    8'd64,  8'd32,  8'd0,  8'd0);
        set_vec( 2, 1'b1, 1'b0, 2'd2, 8'd2,    8'd0,    8'd64,  8'd32,  8'd2,  8'd0);
        set_vec( 3, 1'b1, 1'b0, 2'd3, 8'd1,    8'd0,    8'd64,  8'd32,  8'd2,  8'd1);
        set_vec( 4, 1'b0, 1'b1, 2'd1, 8'hAA,   8'd32,   8'd64,  8'd32,  8'd2,  8'd1);
        set_vec( 5, 1'b0, 1'b1, 2'd1, 8'h11,   8'd32,   8'd64,  8'd32,  8'd2,  8'd1);
        set_vec( 6, 1'b0, 1'b1, 2'd3, 8'h22,   8'd1,    8'd64,  8'd32,  8'd2,  8'd1);
        set_vec( 7, 1'b1, 1'b1, 2'd1, 8'd123,  8'd123,  8'd64,  C2D,    8'd2,  8'd1);
        set_vec( 8, 1'b0, 1'b0, 2'd2, 8'h55,   8'd123,  8'd64,  C2D,    8'd2,  8'd1);
        set_vec( 9, 1'b0, 1'b0, 2'd0, 8'hFF,   8'd123,  8'd64,  C2D,    8'd2,  8'd1);
        set_vec(10, 1'b1, 1'b0, 2'd0, 8'hFF,   8'd123,  8'hFF,  C2D,    8'd2,  8'd1);
        set_vec(11, 1'b0, 1'b1, 2'd0, 8'h00,   8'hFF,   8'hFF,  C2D,    8'd2,  8'd1);
        set_vec(12, 1'b1, 1'b1, 2'd3, 8'h00,   8'h00,   8'hFF,  C2D,    8'd2,  C4D);
        set_vec(13, 1'b0, 1'b1, 2'd3, 8'h5A,   C4D,     8'hFF,  C2D,    8'd2,  C4D);

        // Reset held with random inputs toggling
        rst_ni      = 1'b0;
        data_i      = 8'h00;
        adr_i       = 2'd0;
        read_sig_i  = 1'b0;
        write_sig_i = 1'b0;
        #1;
        chk_all("rst_async", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            data_i      = 8'($urandom);
            adr_i       = 2'($urandom);
            read_sig_i  = 1'($urandom);
            write_sig_i = 1'($urandom);
            @(posedge clk_i);
            #1;
            chk_all("rst_hold", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        end

        // Deassert with strobes low
        @(negedge clk_i);
        read_sig_i  = 1'b0;
        write_sig_i = 1'b0;
        rst_ni      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i);
            #1;
            chk_all("rst_release", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        end

        // Table-driven command sequence
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            read_sig_i  = vecs[i].rd;
            write_sig_i = vecs[i].wr;
            adr_i       = vecs[i].adr;
            data_i      = vecs[i].din;
            @(posedge clk_i);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].c1,
                    vecs[i].c2, vecs[i].c3, vecs[i].c4);
        end

        // Async reset between edges while a store is pending
        @(negedge clk_i);
        read_sig_i  = 1'b1;
        write_sig_i = 1'b0;
        adr_i       = 2'd1;
        data_i      = 8'h99;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all("rst_mid_now", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge clk_i);
        #1;
        chk_all("rst_mid_edge", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk_i);
        read_sig_i = 1'b0;
        rst_ni     = 1'b1;
        @(posedge clk_i);
        #1;
        chk_all("rst_mid_after", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        // Store then fetch on next edge after reset recovery
        @(negedge clk_i);
        read_sig_i = 1'b1;
        adr_i      = 2'd2;
        data_i     = 8'h3C;
        @(posedge clk_i);
        #1;
        chk_all("post_store", 8'd0, 8'd0, 8'd0, 8'h3C, 8'd0);
        @(negedge clk_i);
        read_sig_i  = 1'b0;
        write_sig_i = 1'b1;
        data_i      = 8'h00;
        @(posedge clk_i);
        #1;
        chk_all("post_fetch", 8'h3C, 8'd0, 8'd0, 8'h3C, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
